// File: rtl/change_dispenser.sv
// Change dispenser: pays an owed amount (in 5-cent units) from a big-coin (10c)
// and a small-coin (5c) hopper, preferring big coins, with an acknowledge timeout.
module change_dispenser #(
    parameter int AMT_W      = 6,
    parameter int STOCK_W    = 4,
    parameter int BIG_INIT   = 8,
    parameter int SMALL_INIT = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [AMT_W-1:0]   amount,
    input  logic               refill,
    input  logic               hop_ack,
    output logic               eject_big,
    output logic               eject_small,
    output logic               busy,
    output logic               done,
    output logic               short,
    output logic               fault,
    output logic [AMT_W-1:0]   remain,
    output logic [STOCK_W-1:0] stock_big,
    output logic [STOCK_W-1:0] stock_small
);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        WAIT_ACK
    } state_t;

    // The wait counter only ever holds 0 .. TIMEOUT-1.
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]   TMR_LAST     = TMR_W'(TIMEOUT - 1);
    localparam logic [STOCK_W-1:0] BIG_RELOAD   = STOCK_W'(BIG_INIT);
    localparam logic [STOCK_W-1:0] SMALL_RELOAD = STOCK_W'(SMALL_INIT);
    localparam logic [AMT_W-1:0]   BIG_VALUE    = AMT_W'(2);
    localparam logic [AMT_W-1:0]   SMALL_VALUE  = AMT_W'(1);

    state_t             state;
    state_t             state_nx;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_nx;
    logic [AMT_W-1:0]   remain_nx;
    logic [STOCK_W-1:0] stock_big_nx;
    logic [STOCK_W-1:0] stock_small_nx;
    logic               eject_big_nx;
    logic               eject_small_nx;
    logic               busy_nx;
    logic               done_nx;
    logic               short_nx;
    logic               fault_nx;
    logic               big_ok;
    logic               small_ok;

    // A big coin is only usable when at least two units are owed, so a
    // remainder of one can never be overpaid.
    assign big_ok   = (remain >= BIG_VALUE) && (stock_big != '0);
    assign small_ok = (remain != '0) && (stock_small != '0);

    // Next-state and next-output logic; every output is computed here and
    // registered below so nothing combinational reaches the ports.
    always_comb begin
        state_nx       = state;
        timer_nx       = timer;
        remain_nx      = remain;
        stock_big_nx   = stock_big;
        stock_small_nx = stock_small;
        eject_big_nx   = eject_big;
        eject_small_nx = eject_small;
        done_nx        = 1'b0;
        short_nx       = 1'b0;
        fault_nx       = 1'b0;

        case (state)
            IDLE: begin
                eject_big_nx   = 1'b0;
                eject_small_nx = 1'b0;
                timer_nx       = '0;
                if (req) begin
                    remain_nx = amount;
                    state_nx  = SELECT;
                end else if (refill) begin
                    stock_big_nx   = BIG_RELOAD;
                    stock_small_nx = SMALL_RELOAD;
                end
            end

            SELECT: begin
                eject_big_nx   = 1'b0;
                eject_small_nx = 1'b0;
                timer_nx       = '0;
                if (remain == '0) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else if (big_ok) begin
                    eject_big_nx = 1'b1;
                    state_nx     = WAIT_ACK;
                end else if (small_ok) begin
                    eject_small_nx = 1'b1;
                    state_nx       = WAIT_ACK;
                end else begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    short_nx = 1'b1;
                end
            end

            WAIT_ACK: begin
                if (hop_ack) begin
                    eject_big_nx   = 1'b0;
                    eject_small_nx = 1'b0;
                    timer_nx       = '0;
                    state_nx       = SELECT;
                    if (eject_big) begin
                        stock_big_nx = stock_big - STOCK_W'(1);
                        remain_nx    = remain - BIG_VALUE;
                    end else begin
                        stock_small_nx = stock_small - STOCK_W'(1);
                        remain_nx      = remain - SMALL_VALUE;
                    end
                end else if (timer == TMR_LAST) begin
                    eject_big_nx   = 1'b0;
                    eject_small_nx = 1'b0;
                    timer_nx       = '0;
                    state_nx       = IDLE;
                    done_nx        = 1'b1;
                    fault_nx       = 1'b1;
                end else begin
                    timer_nx = timer + TMR_W'(1);
                end
            end

            default: begin
                eject_big_nx   = 1'b0;
                eject_small_nx = 1'b0;
                timer_nx       = '0;
                state_nx       = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    // State and output registers; reset reloads the hoppers and aborts any
    // payout in progress, including one waiting on the hopper.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            remain      <= '0;
            stock_big   <= BIG_RELOAD;
            stock_small <= SMALL_RELOAD;
            eject_big   <= 1'b0;
            eject_small <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            short       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            remain      <= remain_nx;
            stock_big   <= stock_big_nx;
            stock_small <= stock_small_nx;
            eject_big   <= eject_big_nx;
            eject_small <= eject_small_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            short       <= short_nx;
            fault       <= fault_nx;
        end
    end

endmodule
